// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants, operand-source encoding and bus slicing for the register file
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int REG_ZERO   = 0;

  typedef enum logic [1:0] {
    SRC_ZERO,
    SRC_FWD,
    SRC_WB,
    SRC_ARRAY
  } src_e;

  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - busy bits for registers owned by long-latency writers
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   set,
  input  logic [ADDR_W-1:0]      set_addr,
  input  logic                   clr,
  input  logic [ADDR_W-1:0]      clr_addr,
  output logic [2**ADDR_W-1:0]   busy
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] busy_q;

  // Set is evaluated after clear so the younger issuing op keeps ownership.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      for (int k = 1; k < DEPTH; k++) begin
        if (set && set_addr == ADDR_W'(k)) begin
          busy_q[k] <= 1'b1;
        end else if (clr && clr_addr == ADDR_W'(k)) begin
          busy_q[k] <= 1'b0;
        end
      end
      busy_q[REG_ZERO] <= 1'b0;
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/regfile_bypass.sv
// rtl/regfile_bypass.sv - multi-port register file with youngest-first forwarding, load-use and scoreboard stall
module regfile_bypass
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NRD    = 2,
  parameter int NFWD   = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NRD-1:0]           rd_en,
  input  logic [NRD*ADDR_W-1:0]    raddr,
  output logic [NRD*DATA_W-1:0]    rdata,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [NFWD-1:0]          fwd_wreg,
  input  logic [NFWD*ADDR_W-1:0]   fwd_waddr,
  input  logic [NFWD*DATA_W-1:0]   fwd_wdata,
  input  logic [NFWD-1:0]          fwd_rdy,
  input  logic                     sb_set,
  input  logic [ADDR_W-1:0]        sb_set_addr,
  input  logic                     sb_clr,
  input  logic [ADDR_W-1:0]        sb_clr_addr,
  output logic                     stall
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int FW    = (NFWD > 1) ? $clog2(NFWD) : 1;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [NRD-1:0]    hazard;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem[k] <= '0;
      end
    end else if (we && waddr != ZERO_ADDR) begin
      mem[waddr] <= wdata;
    end
  end

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set      (sb_set),
    .set_addr (sb_set_addr),
    .clr      (sb_clr),
    .clr_addr (sb_clr_addr),
    .busy     (busy)
  );

  for (genvar i = 0; i < NRD; i++) begin : g_port
    logic [ADDR_W-1:0] ra;
    src_e              src;
    logic [FW-1:0]     fsel;
    logic [DATA_W-1:0] rd;
    logic              haz;

    assign ra = raddr[slice_lo(i, ADDR_W) +: ADDR_W];

    // Walk oldest to youngest so the lowest-index (youngest) match lands last.
    always_comb begin
      src  = SRC_ARRAY;
      fsel = '0;
      if (we && waddr == ra) begin
        src = SRC_WB;
      end
      for (int j = NFWD - 1; j >= 0; j--) begin
        if (fwd_wreg[j] && fwd_waddr[slice_lo(j, ADDR_W) +: ADDR_W] == ra) begin
          src  = SRC_FWD;
          fsel = FW'(j);
        end
      end
      if (ra == ZERO_ADDR) begin
        src = SRC_ZERO;
      end
    end

    always_comb begin
      rd  = '0;
      haz = 1'b0;
      case (src)
        SRC_ZERO: rd = '0;
        SRC_FWD: begin
          rd  = fwd_wdata[slice_lo(int'(fsel), DATA_W) +: DATA_W];
          haz = !fwd_rdy[fsel];
        end
        SRC_WB:  rd = wdata;
        default: begin
          rd  = mem[ra];
          haz = busy[ra];
        end
      endcase
    end

    assign rdata[slice_lo(i, DATA_W) +: DATA_W] = rd;
    assign hazard[i] = rd_en[i] & haz;
  end

  assign stall = |hazard;

endmodule

// File: tb/tb_regfile_bypass.sv
// tb/tb_regfile_bypass.sv - directed and randomized checks of regfile_bypass against a behavioural model
module tb_regfile_bypass;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  rd_en;
  logic [4:0]  ra [2];
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [2:0]  fwreg;
  logic [4:0]  fa [3];
  logic [31:0] fd [3];
  logic [2:0]  frdy;
  logic [14:0] fwd_waddr;
  logic [95:0] fwd_wdata;
  logic        sb_set, sb_clr;
  logic [4:0]  sb_set_addr, sb_clr_addr;
  logic        stall;

  logic [31:0] m_regs [32];
  logic        m_busy [32];

  int passed = 0;
  int total  = 0;

  assign raddr     = {ra[1], ra[0]};
  assign fwd_waddr = {fa[2], fa[1], fa[0]};
  assign fwd_wdata = {fd[2], fd[1], fd[0]};

  always #5 clk = ~clk;

  regfile_bypass dut (
    .clk         (clk),
    .rst         (rst),
    .rd_en       (rd_en),
    .raddr       (raddr),
    .rdata       (rdata),
    .we          (we),
    .waddr       (waddr),
    .wdata       (wdata),
    .fwd_wreg    (fwreg),
    .fwd_waddr   (fwd_waddr),
    .fwd_wdata   (fwd_wdata),
    .fwd_rdy     (frdy),
    .sb_set      (sb_set),
    .sb_set_addr (sb_set_addr),
    .sb_clr      (sb_clr),
    .sb_clr_addr (sb_clr_addr),
    .stall       (stall)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [31:0] port_data(input int p);
    return rdata[p*32 +: 32];
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 32; k++) begin
      m_regs[k] = '0;
      m_busy[k] = 1'b0;
    end
  endtask

  // Model operand lookup: returns value and whether the operand is not yet available.
  task automatic m_read(input int p, output logic [31:0] val, output logic blocked);
    logic [4:0] a;
    a = ra[p];
    blocked = 1'b0;
    if (a == 0) begin
      val = 0;
      return;
    end
    for (int j = 0; j < 3; j++) begin
      if (fwreg[j] && fa[j] == a) begin
        val = fd[j];
        blocked = !frdy[j];
        return;
      end
    end
    if (we && waddr == a) begin
      val = wdata;
      return;
    end
    val = m_regs[a];
    blocked = m_busy[a];
  endtask

  task automatic idle();
    rd_en = 0; ra[0] = 0; ra[1] = 0;
    we = 0; waddr = 0; wdata = 0;
    fwreg = 0; frdy = 0;
    for (int j = 0; j < 3; j++) begin
      fa[j] = 0;
      fd[j] = 0;
    end
    sb_set = 0; sb_set_addr = 0; sb_clr = 0; sb_clr_addr = 0;
  endtask

  // Advance one edge, updating the model from the inputs held across it.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_reset();
    end else begin
      if (we && waddr != 0) m_regs[waddr] = wdata;
      if (sb_clr) m_busy[sb_clr_addr] = 1'b0;
      if (sb_set && sb_set_addr != 0) m_busy[sb_set_addr] = 1'b1;
    end
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    logic [31:0] ev0, ev1;
    logic        eb0, eb1;

    idle();
    rst = 1'b1;
    m_reset();
    tick();
    tick();
    ra[0] = 5'd1; ra[1] = 5'd31; rd_en = 2'b11;
    settle();
    chk("reset_rdata0", port_data(0), 32'h0);
    chk("reset_rdata1", port_data(1), 32'h0);
    chk("reset_stall", {31'b0, stall}, 32'h0);
    rst = 1'b0;
    tick();

    // Reset mid-operation
    idle();
    we = 1; waddr = 5; wdata = 32'h0000_1234; ra[0] = 5; rd_en = 1;
    settle();
    chk("wr_bypass_r5", port_data(0), 32'h0000_1234);
    tick();
    we = 0;
    settle();
    chk("array_r5", port_data(0), 32'h0000_1234);
    rst = 1'b1;
    m_reset();
    #1;
    chk("rst_pulse_r5", port_data(0), 32'h0);
    rst = 1'b0;
    #1;
    chk("rst_release_r5", port_data(0), 32'h0);
    tick();
    settle();
    chk("post_rst_r5", port_data(0), 32'h0);

    // Forwarding priority
    idle();
    fwreg = 3'b111; frdy = 3'b111;
    fa[0] = 3; fa[1] = 3; fa[2] = 3;
    fd[0] = 32'hA; fd[1] = 32'hB; fd[2] = 32'hC;
    we = 1; waddr = 3; wdata = 32'hD; ra[1] = 3; rd_en = 2'b10;
    settle();
    chk("prio_fwd0", port_data(1), 32'hA);
    fwreg = 3'b110;
    settle();
    chk("prio_fwd1", port_data(1), 32'hB);
    fwreg = 3'b000;
    settle();
    chk("prio_wb", port_data(1), 32'hD);
    tick();
    we = 0;
    settle();
    chk("prio_array", port_data(1), 32'hD);

    // Register zero immunity
    idle();
    we = 1; waddr = 0; wdata = 32'hFFFF_FFFF;
    fwreg = 3'b001; fa[0] = 0; fd[0] = 32'h1111; frdy = 0;
    sb_set = 1; sb_set_addr = 0; ra[0] = 0; rd_en = 1;
    settle();
    chk("r0_data", port_data(0), 32'h0);
    chk("r0_stall", {31'b0, stall}, 32'h0);
    tick();
    idle();
    ra[0] = 0; rd_en = 1;
    settle();
    chk("r0_data_after", port_data(0), 32'h0);
    chk("r0_stall_after", {31'b0, stall}, 32'h0);

    // Load-use
    idle();
    fwreg = 3'b011; fa[0] = 7; fa[1] = 7; fd[0] = 32'h77; fd[1] = 32'h99;
    frdy = 3'b010; ra[0] = 7; rd_en = 1;
    settle();
    chk("lu_stall", {31'b0, stall}, 32'h1);
    rd_en = 0;
    settle();
    chk("lu_noread", {31'b0, stall}, 32'h0);
    rd_en = 1; frdy = 3'b011;
    settle();
    chk("lu_ready_stall", {31'b0, stall}, 32'h0);
    chk("lu_ready_data", port_data(0), 32'h77);
    tick();

    // Scoreboard set then clear with write bypass
    idle();
    sb_set = 1; sb_set_addr = 9;
    tick();
    sb_set = 0; ra[0] = 9; rd_en = 1;
    for (int c = 2; c <= 4; c++) begin
      settle();
      chk($sformatf("sb_busy_c%0d", c), {31'b0, stall}, 32'h1);
      tick();
    end
    we = 1; waddr = 9; wdata = 32'h55; sb_clr = 1; sb_clr_addr = 9;
    settle();
    chk("sb_wr_data", port_data(0), 32'h55);
    chk("sb_wr_stall", {31'b0, stall}, 32'h0);
    tick();
    we = 0; sb_clr = 0;
    settle();
    chk("sb_after_data", port_data(0), 32'h55);
    chk("sb_after_stall", {31'b0, stall}, 32'h0);

    // Simultaneous set and clear
    idle();
    sb_set = 1; sb_set_addr = 4;
    tick();
    sb_clr = 1; sb_clr_addr = 4;
    tick();
    idle();
    ra[0] = 4; rd_en = 1;
    settle();
    chk("setclr_same", {31'b0, stall}, 32'h1);
    sb_set = 1; sb_set_addr = 6;
    tick();
    sb_set = 1; sb_set_addr = 4; sb_clr = 1; sb_clr_addr = 6;
    tick();
    idle();
    ra[0] = 4; ra[1] = 6; rd_en = 2'b01;
    settle();
    chk("setclr_r4_busy", {31'b0, stall}, 32'h1);
    rd_en = 2'b10;
    settle();
    chk("setclr_r6_free", {31'b0, stall}, 32'h0);
    tick();

    // Randomized traffic on a narrow address range to force collisions
    for (int n = 0; n < 400; n++) begin
      rd_en = 2'($urandom);
      ra[0] = 5'($urandom_range(0, 7));
      ra[1] = 5'($urandom_range(0, 7));
      we = ($urandom_range(0, 2) != 0);
      waddr = 5'($urandom_range(0, 7));
      wdata = $urandom;
      fwreg = 3'($urandom);
      frdy = 3'($urandom | $urandom);
      for (int j = 0; j < 3; j++) begin
        fa[j] = 5'($urandom_range(0, 7));
        fd[j] = $urandom;
      end
      sb_set = ($urandom_range(0, 5) == 0);
      sb_set_addr = 5'($urandom_range(0, 7));
      sb_clr = ($urandom_range(0, 2) == 0);
      sb_clr_addr = 5'($urandom_range(0, 7));
      settle();
      m_read(0, ev0, eb0);
      m_read(1, ev1, eb1);
      chk($sformatf("rnd%0d_stall", n), {31'b0, stall},
          {31'b0, (rd_en[0] & eb0) | (rd_en[1] & eb1)});
      if (!((rd_en[0] & eb0) | (rd_en[1] & eb1))) begin
        chk($sformatf("rnd%0d_rdata0", n), port_data(0), ev0);
        chk($sformatf("rnd%0d_rdata1", n), port_data(1), ev1);
      end
      if (n % 97 == 50) begin
        rst = 1'b1;
        m_reset();
        #1;
        rst = 1'b0;
      end
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
